// File: rtl/vc_fifo_memory_if.sv
// vc_fifo_memory_if: push/pop request and status bundle for the multi-channel FIFO memory
interface vc_fifo_memory_if #(
  parameter int MAIN_SIZE = 3,
  parameter int DATA_SIZE = 10,
  parameter int CH_SIZE   = 2
);
  localparam int CHANNELS = 2**CH_SIZE;
  logic                 push;
  logic [CH_SIZE-1:0]   push_ch;
  logic [DATA_SIZE-1:0] data_in;
  logic                 pop;
  logic [CH_SIZE-1:0]   pop_ch;
  logic [DATA_SIZE-1:0] data_out;
  logic                 data_out_valid;
  logic [CHANNELS-1:0]  full;
  logic [CHANNELS-1:0]  empty;
  logic [CHANNELS-1:0]  almost_full;
  logic [CHANNELS-1:0]  almost_empty;
  logic [CHANNELS-1:0]  overflow_err;
  logic [CHANNELS-1:0]  underflow_err;
  modport master (
    output push, push_ch, data_in, pop, pop_ch,
    input  data_out, data_out_valid, full, empty, almost_full, almost_empty,
           overflow_err, underflow_err
  );
  modport slave (
    input  push, push_ch, data_in, pop, pop_ch,
    output data_out, data_out_valid, full, empty, almost_full, almost_empty,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_fifo_memory.sv
// vc_fifo_memory: per-virtual-channel circular FIFOs sharing one storage array
module vc_fifo_memory #(
  parameter int MAIN_SIZE = 3,
  parameter int DATA_SIZE = 10,
  parameter int CH_SIZE   = 2,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input logic clk,
  input logic reset,
  vc_fifo_memory_if.slave bus
);
  localparam int DEPTH    = 2**MAIN_SIZE;
  localparam int CHANNELS = 2**CH_SIZE;
  localparam logic [MAIN_SIZE:0] FULL_C = (MAIN_SIZE+1)'(DEPTH);
  localparam logic [MAIN_SIZE:0] AF_C   = (MAIN_SIZE+1)'(AF_THRESH);
  localparam logic [MAIN_SIZE:0] AE_C   = (MAIN_SIZE+1)'(AE_THRESH);
  logic [DATA_SIZE-1:0] mem_q    [CHANNELS*DEPTH];
  logic [MAIN_SIZE-1:0] wr_ptr_q [CHANNELS];
  logic [MAIN_SIZE-1:0] rd_ptr_q [CHANNELS];
  logic [MAIN_SIZE:0]   cnt_q    [CHANNELS];
  logic [MAIN_SIZE:0]   cnt_d    [CHANNELS];
  logic [DATA_SIZE-1:0] dout_q;
  logic                 dv_q;
  logic [CHANNELS-1:0]  ovf_q, udf_q, full, empty;
  logic                 push_ok, pop_ok;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_flag
    assign full[c]             = cnt_q[c] == FULL_C;
    assign empty[c]            = cnt_q[c] == '0;
    assign bus.almost_full[c]  = cnt_q[c] >= AF_C;
    assign bus.almost_empty[c] = cnt_q[c] <= AE_C;
  end
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dv_q;
  assign bus.overflow_err   = ovf_q;
  assign bus.underflow_err  = udf_q;
  assign push_ok = bus.push && !full[bus.push_ch];
  assign pop_ok  = bus.pop && !empty[bus.pop_ch];
  // a push and pop both landing on one channel cancel out in its count
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      cnt_d[i] = cnt_q[i]
               + (MAIN_SIZE+1)'(push_ok && bus.push_ch == CH_SIZE'(i))
               - (MAIN_SIZE+1)'(pop_ok && bus.pop_ch == CH_SIZE'(i));
  end
  always_ff @(posedge clk)
    if (!reset && push_ok) mem_q[{bus.push_ch, wr_ptr_q[bus.push_ch]}] <= bus.data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      dout_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= '0;
      udf_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q[bus.push_ch] <= wr_ptr_q[bus.push_ch] + MAIN_SIZE'(1);
      if (pop_ok) begin
        dout_q                <= mem_q[{bus.pop_ch, rd_ptr_q[bus.pop_ch]}];
        rd_ptr_q[bus.pop_ch]  <= rd_ptr_q[bus.pop_ch] + MAIN_SIZE'(1);
      end
      if (bus.push && !push_ok) ovf_q[bus.push_ch] <= 1'b1;
      if (bus.pop && !pop_ok) udf_q[bus.pop_ch] <= 1'b1;
      dv_q  <= pop_ok;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_vc_fifo_memory.sv
// tb_vc_fifo_memory: vector table, corner sequences and random traffic against a queue model
module tb_vc_fifo_memory;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  vc_fifo_memory_if bus ();
  vc_fifo_memory dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [9:0] mq [4][$];
  logic [9:0] m_dout;
  logic       m_valid;
  logic [3:0] m_ovf, m_udf;
  typedef struct {
    logic       push;
    logic [1:0] pch;
    logic [9:0] din;
    logic       pop;
    logic [1:0] och;
    logic       ev;
    logic [9:0] ed;
  } vec_t;
  vec_t vec [11];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic model_reset();
    for (int c = 0; c < 4; c++) mq[c].delete();
    m_dout = '0;
    m_valid = 1'b0;
    m_ovf = '0;
    m_udf = '0;
  endtask
  task automatic model_step(input logic p, input logic [1:0] pc, input logic [9:0] d,
                            input logic o, input logic [1:0] oc);
    bit pa, oa;
    pa = p && mq[pc].size() < 8;
    oa = o && mq[oc].size() > 0;
    if (p && !pa) m_ovf[pc] = 1'b1;
    if (o && !oa) m_udf[oc] = 1'b1;
    m_valid = oa;
    if (oa) m_dout = mq[oc].pop_front();
    if (pa) mq[pc].push_back(d);
  endtask
  task automatic compare_all(input string tag);
    logic [3:0] ef, ee, eaf, eae;
    for (int c = 0; c < 4; c++) begin
      ef[c]  = mq[c].size() == 8;
      ee[c]  = mq[c].size() == 0;
      eaf[c] = mq[c].size() >= 6;
      eae[c] = mq[c].size() <= 1;
    end
    chk({tag, ".valid"}, 32'(bus.data_out_valid), 32'(m_valid));
    chk({tag, ".dout"}, 32'(bus.data_out), 32'(m_dout));
    chk({tag, ".full"}, 32'(bus.full), 32'(ef));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(ee));
    chk({tag, ".afull"}, 32'(bus.almost_full), 32'(eaf));
    chk({tag, ".aempty"}, 32'(bus.almost_empty), 32'(eae));
    chk({tag, ".ovf"}, 32'(bus.overflow_err), 32'(m_ovf));
    chk({tag, ".udf"}, 32'(bus.underflow_err), 32'(m_udf));
  endtask
  task automatic apply(input string tag, input logic p, input logic [1:0] pc,
                       input logic [9:0] d, input logic o, input logic [1:0] oc);
    bus.push = p;
    bus.push_ch = pc;
    bus.data_in = d;
    bus.pop = o;
    bus.pop_ch = oc;
    @(posedge clk);
    model_step(p, pc, d, o, oc);
    #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    compare_all(tag);
  endtask
  task automatic do_reset(input string tag);
    reset = 1'b1;
    bus.push = 1'b1;
    bus.push_ch = 2'd1;
    bus.data_in = 10'h2A5;
    bus.pop = 1'b1;
    bus.pop_ch = 2'd0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    chk({tag, ".rst_valid"}, 32'(bus.data_out_valid), 32'd0);
    chk({tag, ".rst_dout"}, 32'(bus.data_out), 32'd0);
    chk({tag, ".rst_empty"}, 32'(bus.empty), 32'hF);
    chk({tag, ".rst_aempty"}, 32'(bus.almost_empty), 32'hF);
    compare_all(tag);
  endtask
  initial begin
    vec[0]  = '{1'b1, 2'd0, 10'h0FF, 1'b0, 2'd0, 1'b0, 10'h000};
    vec[1]  = '{1'b1, 2'd0, 10'h0DD, 1'b0, 2'd0, 1'b0, 10'h000};
    vec[2]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd0, 1'b1, 10'h0FF};
    vec[3]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd0, 1'b1, 10'h0DD};
    vec[4]  = '{1'b0, 2'd0, 10'h000, 1'b0, 2'd0, 1'b0, 10'h0DD};
    vec[5]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd1, 1'b0, 10'h0DD};
    vec[6]  = '{1'b1, 2'd1, 10'h022, 1'b0, 2'd0, 1'b0, 10'h0DD};
    vec[7]  = '{1'b1, 2'd0, 10'h011, 1'b1, 2'd1, 1'b1, 10'h022};
    vec[8]  = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd0, 1'b1, 10'h011};
    vec[9]  = '{1'b1, 2'd0, 10'h123, 1'b1, 2'd0, 1'b0, 10'h011};
    vec[10] = '{1'b0, 2'd0, 10'h000, 1'b1, 2'd0, 1'b1, 10'h123};
    bus.push = 1'b0;
    bus.push_ch = '0;
    bus.data_in = '0;
    bus.pop = 1'b0;
    bus.pop_ch = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");
    for (int i = 0; i < 11; i++) begin
      apply($sformatf("vec%0d", i), vec[i].push, vec[i].pch, vec[i].din, vec[i].pop, vec[i].och);
      chk($sformatf("vec%0d.ev", i), 32'(bus.data_out_valid), 32'(vec[i].ev));
      chk($sformatf("vec%0d.ed", i), 32'(bus.data_out), 32'(vec[i].ed));
    end
    for (int i = 0; i < 8; i++) apply("fill2", 1'b1, 2'd2, 10'(10'h100 + i), 1'b0, 2'd0);
    apply("ovf2", 1'b1, 2'd2, 10'h3AA, 1'b0, 2'd0);
    chk("ovf2.full", 32'(bus.full[2]), 32'd1);
    chk("ovf2.err", 32'(bus.overflow_err[2]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      apply("drain2", 1'b0, 2'd0, 10'h0, 1'b1, 2'd2);
      chk("drain2.data", 32'(bus.data_out), 32'h100 + 32'(i));
    end
    chk("udf1.sticky", 32'(bus.underflow_err[1]), 32'd1);
    for (int i = 0; i < 4; i++) apply("fill3", 1'b1, 2'd3, 10'(10'h200 + i), 1'b0, 2'd0);
    for (int i = 0; i < 12; i++) begin
      apply("wrap3", 1'b1, 2'd3, 10'h055, 1'b1, 2'd3);
      chk("wrap3.data", 32'(bus.data_out), (i < 4) ? 32'h200 + 32'(i) : 32'h055);
      chk("wrap3.count", 32'({bus.empty[3], bus.full[3], bus.almost_full[3], bus.almost_empty[3]}), 32'd0);
    end
    do_reset("rst1");
    for (int i = 0; i < 6; i++) begin
      apply("af0", 1'b1, 2'd0, 10'(10'h010 + i), 1'b0, 2'd0);
      chk("af0.edge", 32'(bus.almost_full[0]), 32'(i >= 5));
    end
    for (int i = 0; i < 5; i++) apply("ae0", 1'b0, 2'd0, 10'h0, 1'b1, 2'd0);
    chk("ae0.flag", 32'(bus.almost_empty[0]), 32'd1);
    chk("ae0.nempty", 32'(bus.empty[0]), 32'd0);
    do_reset("rst2");
    for (int i = 0; i < 600; i++) begin
      logic [1:0] pc, oc;
      pc = (i < 300) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      oc = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : pc;
      apply("rand", $urandom_range(0, 9) < 6, pc, 10'($urandom), $urandom_range(0, 9) < 5, oc);
    end
    do_reset("rst3");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vc_fifo_memory.md
Name: vc_fifo_memory

Overview:
- Multi-channel buffer memory: CHANNELS independent circular FIFOs (one per PCIe virtual channel) sharing one storage array of CHANNELS*DEPTH words.
- Generalises the single-port pointer memory. Pointers are now internal, and per-channel occupancy, full/empty and threshold flags are added, along with sticky error flags.
- Sits between the lane/packet front-end and the switching arbiter, which uses almost_full/almost_empty for flow control.

Parameters:
- MAIN_SIZE, 3, log2 of per-channel depth (DEPTH = 2**MAIN_SIZE = 8 words).
- DATA_SIZE, 10, word width in bits.
- CH_SIZE, 2, log2 of channel count (CHANNELS = 2**CH_SIZE = 4).
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- push  in  1  write request.
- push_ch  in  CH_SIZE  target channel for push.
- data_in  in  DATA_SIZE  write data.
- pop  in  1  read request.
- pop_ch  in  CH_SIZE  source channel for pop.
- data_out  out  DATA_SIZE  registered read data.
- data_out_valid  out  1  data_out carries a newly popped word this cycle.
- full  out  CHANNELS  per-channel full (bit i = channel i).
- empty  out  CHANNELS  per-channel empty.
- almost_full  out  CHANNELS  per-channel count >= AF_THRESH.
- almost_empty  out  CHANNELS  per-channel count <= AE_THRESH.
- overflow_err  out  CHANNELS  sticky: push was rejected on a full channel.
- underflow_err  out  CHANNELS  sticky: pop was rejected on an empty channel.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset; it overrides all other inputs on the same edge.
- Reset values:
  - All wr/rd pointers = 0; all counts = 0.
  - data_out = 0; data_out_valid = 0.
  - empty = all 1s; full = 0.
  - almost_empty = all 1s; almost_full = 0.
  - overflow_err = 0; underflow_err = 0.
  - Memory contents are not cleared.
- Per-channel state:
  - wr_ptr and rd_ptr are MAIN_SIZE bits each.
  - count is MAIN_SIZE+1 bits, range 0..DEPTH.
  - Physical address = {channel, ptr}.
- Flags are combinational from the registered counts:
  - full = (count == DEPTH); empty = (count == 0).
  - almost_full = (count >= AF_THRESH); almost_empty = (count <= AE_THRESH).
- Push accept: push && !full[push_ch] (pre-edge state).
  - On accept: mem[{push_ch, wr_ptr}] <= data_in; wr_ptr += 1, wrapping DEPTH-1 -> 0.
- Pop accept: pop && !empty[pop_ch] (pre-edge state).
  - On accept: data_out <= mem[{pop_ch, rd_ptr}]; rd_ptr += 1 with wrap; data_out_valid <= 1.
  - Read latency is 1 cycle: data is visible the cycle after the pop edge.
- No pop accepted: data_out_valid <= 0; data_out holds its last value.
- Count update per channel:
  - +1 for an accepted push only; -1 for an accepted pop only.
  - Unchanged if both or neither are accepted for that channel.
- Push and pop on different channels in the same cycle: fully independent, both may succeed.
- Push and pop on the same channel in the same cycle:
  - count between 1 and DEPTH-1: both succeed, count unchanged, and the popped word is the old head.
  - full: pop succeeds, push is rejected and overflow_err set. No pass-through on full.
  - empty: push succeeds, pop is rejected and underflow_err set. No bypass; the word is readable the next cycle.
- Rejected operations: storage, pointers and count are unchanged. The matching err bit is set and stays set until reset.
- Wrap-around: pointers wrap silently; full/empty are decided only by count, never by pointer equality.
- Reset mid-operation: any in-flight push/pop on the reset edge is discarded. data_out_valid = 0 the next cycle.

Test Plan:
- Reset, then channel 0: push 0x0FF, 0x0DD, then pop twice -> data_out = 0x0FF then 0x0DD, each valid for 1 cycle, 1 cycle after its pop. empty[0]=1 afterwards.
- Fill channel 2 with 8 words 0x100..0x107; 9th push of 0x3AA -> full[2]=1 and overflow_err[2]=1. Popping 8 returns 0x100..0x107 in order; 0x3AA is never seen.
- Pop channel 1 while empty -> data_out_valid=0, data_out unchanged, underflow_err[1]=1. It stays 1 after later successful traffic until reset.
- Channel 3 holds 4 words; simultaneous push 0x055 and pop for 12 cycles -> count stays 4, pointers wrap past 7. Output order is FIFO, ending with 0x055 words.
- Interleave: push ch0 0x011 and pop ch1 (holding 0x022) in the same cycle -> data_out=0x022. Counts: ch0=1, ch1=0. Channels stay isolated.
- Push ch0 to 6 words -> almost_full[0] rises exactly on the 6th push edge. Pop down to 1 -> almost_empty[0]=1. Assert reset mid-stream -> every output at its reset value the next cycle.
